// File: rtl/mem_copy_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_copy_engine                                              |
// | Description : Byte-wise memory copy engine. Copies len bytes from src_addr |
// |               to dst_addr in strict forward order through a single-port    |
// |               memory (combinational read, write on posedge CLK).           |
// |               Optional fill mode writes a constant byte instead of copying;|
// |               it is compiled in when the macro MEMCPY_FILL_EN is defined.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_copy_engine (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic [7:0] src_addr,
  input  logic [7:0] dst_addr,
  input  logic [7:0] len,
`ifdef MEMCPY_FILL_EN
  input  logic       fill_mode,
  input  logic [7:0] fill_data,
`endif
  input  logic [7:0] mem_rdata,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] src_q, src_d;
  logic [7:0] dst_q, dst_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] hold_q, hold_d;

  // Fill-mode view: the FSM only ever looks at these, so the copy-only build
  // simply ties them off and the fill branches fold away.
  logic       fill_act;     // latched fill mode of the running transfer
  logic       fill_req;     // fill mode requested on the start cycle
  logic [7:0] fill_byte;    // latched fill value

`ifdef MEMCPY_FILL_EN
  logic       fill_mode_q, fill_mode_d;
  logic [7:0] fill_data_q, fill_data_d;

  assign fill_act  = fill_mode_q;
  assign fill_req  = fill_mode;
  assign fill_byte = fill_data_q;

  // Fill parameters are captured together with the rest of the request.
  always_comb begin
    fill_mode_d = fill_mode_q;
    fill_data_d = fill_data_q;
    if (state_q == S_IDLE && start) begin
      fill_mode_d = fill_mode;
      fill_data_d = fill_data;
    end
  end

  // Fill parameter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fill_mode_q <= 1'b0;
      fill_data_q <= 8'h00;
    end else begin
      fill_mode_q <= fill_mode_d;
      fill_data_q <= fill_data_d;
    end
  end
`else
  assign fill_act  = 1'b0;
  assign fill_req  = 1'b0;
  assign fill_byte = 8'h00;
`endif

  // State, pointer, count and holding registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      src_q   <= 8'h00;
      dst_q   <= 8'h00;
      cnt_q   <= 8'h00;
      hold_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic and memory-side outputs. Each byte is read in its own
  // cycle after the previous write has committed, which keeps overlapping
  // forward copies correct (the data propagates byte by byte).
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    mem_addr  = 8'h00;
    mem_wdata = 8'h00;
    mem_we    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d = src_addr;
          dst_d = dst_addr;
          cnt_d = len;
          if (len == 8'd0) begin
            state_d = S_DONE;
          end else if (fill_req) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end

      S_READ: begin
        mem_addr = src_q;
        hold_d   = mem_rdata;
        state_d  = S_WRITE;
      end

      S_WRITE: begin
        mem_addr  = dst_q;
        mem_we    = 1'b1;
        mem_wdata = fill_act ? fill_byte : hold_q;
        // Pointers wrap naturally at 8 bits.
        dst_d     = dst_q + 8'd1;
        cnt_d     = cnt_q - 8'd1;
        if (!fill_act) begin
          src_d = src_q + 8'd1;
        end
        if (cnt_q == 8'd1) begin
          state_d = S_DONE;
        end else if (fill_act) begin
          state_d = S_WRITE;
        end else begin
          state_d = S_READ;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_mem_copy_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_copy_engine                                           |
// | Description : Scoreboard bench for mem_copy_engine. A reference memory     |
// |               image predicts every write; writes are popped and compared   |
// |               as the DUT issues them. Fill tests need MEMCPY_FILL_EN.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_copy_engine;

  logic       CLK = 1'b0;
  logic       RST;
  logic       start;
  logic [7:0] src_addr, dst_addr, len;
  logic [7:0] mem_rdata, mem_addr, mem_wdata;
  logic       mem_we, busy, done;
`ifdef MEMCPY_FILL_EN
  logic       fill_mode;
  logic [7:0] fill_data;
`endif

  mem_copy_engine dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len       (len),
`ifdef MEMCPY_FILL_EN
    .fill_mode (fill_mode),
    .fill_data (fill_data),
`endif
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .busy      (busy),
    .done      (done)
  );

  always #5 CLK = ~CLK;

  // Data memory model with a bench-side preload port.
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic       tb_init, tb_we;
  logic [7:0] tb_addr, tb_wdata;

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 7 + 3);
  endfunction

  assign mem_rdata = mem[mem_addr];

  // Memory write port: DUT first, then bench preload.
  always @(posedge CLK) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else if (tb_we) mem[tb_addr] <= tb_wdata;
    else if (tb_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
    end
  end

  int          checks   = 0;
  int          failures = 0;
  int          wr_cnt   = 0;
  int          done_cnt = 0;
  logic [15:0] exp_q [$];
  logic [15:0] exp_w;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every write the DUT issues is popped and compared.
  always @(negedge CLK) begin
    if (done === 1'b1) done_cnt++;
    if (mem_we === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() > 0) begin
        exp_w = exp_q.pop_front();
        check("write_addr_data", {16'h0, mem_addr, mem_wdata}, {16'h0, exp_w});
      end
    end
  end

  function automatic int mem_diffs();
    int n = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge CLK);
    tb_we = 1'b1; tb_addr = a; tb_wdata = d;
    @(negedge CLK);
    tb_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic init_mem();
    @(negedge CLK);
    tb_init = 1'b1;
    @(negedge CLK);
    tb_init = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
  endtask

  // One transfer: predict writes, pulse start in cycle 0, track cycles.
  task automatic run_xfer(input bit fill, input logic [7:0] s, input logic [7:0] d,
                          input logic [7:0] n, input logic [7:0] fd, input bit poke_busy);
    int         expc, dcyc, busy_bad, wr0;
    logic [7:0] b, sa, da;
    for (int i = 0; i < int'(n); i++) begin
      sa = s + 8'(i);
      da = d + 8'(i);
      b  = fill ? fd : ref_mem[sa];
      ref_mem[da] = b;
      exp_q.push_back({da, b});
    end
    expc = (n == 8'd0) ? 1 : (fill ? int'(n) + 1 : 2 * int'(n) + 1);
    @(negedge CLK);
    wr0 = wr_cnt;
    start = 1'b1; src_addr = s; dst_addr = d; len = n;
`ifdef MEMCPY_FILL_EN
    fill_mode = fill; fill_data = fd;
`endif
    dcyc = 0; busy_bad = 0;
    for (int c = 1; c <= expc + 10 && dcyc == 0; c++) begin
      @(negedge CLK);
      if (c == 1) begin
        start = 1'b0;
        src_addr = 8'($urandom); dst_addr = 8'($urandom); len = 8'($urandom);
`ifdef MEMCPY_FILL_EN
        fill_mode = ~fill; fill_data = 8'($urandom);
`endif
      end
      if (poke_busy && c == 2) start = 1'b1;
      if (c == 3) start = 1'b0;
      if (busy !== 1'b1) busy_bad++;
      if (done === 1'b1) dcyc = c;
    end
    start = 1'b0;
    check("done_cycle", dcyc, expc);
    check("busy_during_xfer", busy_bad, 0);
    @(negedge CLK);
    check("idle_outputs", {13'h0, busy, done, mem_we, mem_addr, mem_wdata}, 32'h0);
    check("write_count", wr_cnt - wr0, {24'h0, n});
    check("queue_left", exp_q.size(), 0);
    check("mem_image", mem_diffs(), 0);
    exp_q.delete();
  endtask

  initial begin
    int wr0, dn0;
    RST = 1'b1; start = 1'b1; src_addr = 8'h10; dst_addr = 8'h40; len = 8'd3;
    tb_init = 1'b0; tb_we = 1'b0; tb_addr = 8'h00; tb_wdata = 8'h00;
`ifdef MEMCPY_FILL_EN
    fill_mode = 1'b0; fill_data = 8'h00;
`endif
    // Reset has priority over a concurrent start.
    repeat (2) @(negedge CLK);
    check("reset_outputs", {13'h0, busy, done, mem_we, mem_addr, mem_wdata}, 32'h0);
    start = 1'b0;
    RST = 1'b0;
    @(negedge CLK);
    check("idle_after_reset", {31'h0, busy}, 32'h0);

    init_mem();

    // Basic copy, with an ignored start pulse while busy.
    poke(8'h10, 8'h0A); poke(8'h11, 8'h0B); poke(8'h12, 8'h0C);
    run_xfer(1'b0, 8'h10, 8'h40, 8'd3, 8'h00, 1'b1);
    check("mem40", {24'h0, mem[8'h40]}, 32'h0A);
    check("mem41", {24'h0, mem[8'h41]}, 32'h0B);
    check("mem42", {24'h0, mem[8'h42]}, 32'h0C);

    // Zero-length transfer.
    run_xfer(1'b0, 8'h00, 8'h90, 8'd0, 8'h00, 1'b0);

    // Source pointer wrap.
    poke(8'hFE, 8'h01); poke(8'hFF, 8'h02); poke(8'h00, 8'h03);
    run_xfer(1'b0, 8'hFE, 8'h20, 8'd3, 8'h00, 1'b0);
    check("mem20", {24'h0, mem[8'h20]}, 32'h01);
    check("mem22", {24'h0, mem[8'h22]}, 32'h03);

    // Overlapping forward copy smears the first byte.
    poke(8'h30, 8'h55);
    run_xfer(1'b0, 8'h30, 8'h31, 8'd4, 8'h00, 1'b0);
    check("mem34", {24'h0, mem[8'h34]}, 32'h55);

    // Reset during cycle 3 of a 5-byte copy: only the first byte lands.
    ref_mem[8'h60] = ref_mem[8'h50];
    exp_q.push_back({8'h60, ref_mem[8'h50]});
    @(negedge CLK);
    wr0 = wr_cnt; dn0 = done_cnt;
    start = 1'b1; src_addr = 8'h50; dst_addr = 8'h60; len = 8'd5;
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLK);
      if (c == 1) start = 1'b0;
      if (c == 3) RST = 1'b1;
      if (c == 4) begin
        check("abort_outputs", {30'h0, busy, mem_we}, 32'h0);
        RST = 1'b0;
      end
    end
    check("abort_no_done", done_cnt - dn0, 0);
    check("abort_write_count", wr_cnt - wr0, 1);
    check("abort_queue_left", exp_q.size(), 0);
    check("abort_mem_image", mem_diffs(), 0);
    exp_q.delete();

    // Normal transfer after the abort, then a few with destination wrap.
    run_xfer(1'b0, 8'h70, 8'hA0, 8'd6, 8'h00, 1'b0);
    run_xfer(1'b0, 8'h05, 8'hFD, 8'd5, 8'h00, 1'b1);
    for (int k = 0; k < 3; k++)
      run_xfer(1'b0, 8'($urandom), 8'($urandom), 8'($urandom_range(1, 20)), 8'h00, 1'b0);

`ifdef MEMCPY_FILL_EN
    // Fill mode with an ignored start pulse in cycle 2.
    run_xfer(1'b1, 8'h00, 8'h80, 8'd4, 8'hA5, 1'b1);
    check("mem80", {24'h0, mem[8'h80]}, 32'hA5);
    check("mem83", {24'h0, mem[8'h83]}, 32'hA5);
    run_xfer(1'b1, 8'h00, 8'hC0, 8'd0, 8'h3C, 1'b0);
    run_xfer(1'b0, 8'h80, 8'hD0, 8'd2, 8'h00, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 SHALL have port: CLK  input  1  single clock; all state updates on posedge CLK.
REQ-002 SHALL have port: RST  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: start  input  1  request a transfer; sampled only in IDLE.
REQ-004 SHALL have port: src_addr  input  8  first source byte address.
REQ-005 SHALL have port: dst_addr  input  8  first destination byte address.
REQ-006 SHALL have port: len  input  8  byte count, 0..255.
REQ-007 SHALL have port: mem_rdata  input  8  data memory read data, combinational from mem_addr.
REQ-008 SHALL have port: mem_addr  output  8  data memory address.
REQ-009 SHALL have port: mem_wdata  output  8  data memory write data.
REQ-010 SHALL have port: mem_we  output  1  data memory write enable; memory commits on posedge CLK.
REQ-011 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port: done  output  1  single-cycle completion pulse.

Function
REQ-013 SHALL implement a 4-state FSM: IDLE, READ, WRITE, DONE.
REQ-014 In IDLE with start=1, SHALL latch src_addr, dst_addr and len into src_ptr, dst_ptr and count. It SHALL go to READ if len!=0 and to DONE if len==0.
REQ-015 In READ, SHALL drive mem_addr=src_ptr and mem_we=0, and SHALL capture mem_rdata into an 8-bit holding register at the closing edge; next state SHALL be WRITE.
REQ-016 In WRITE, SHALL drive mem_addr=dst_ptr, mem_wdata=holding register and mem_we=1. At the closing edge it SHALL increment src_ptr and dst_ptr, decrement count, and go to DONE if count==1, else to READ.
REQ-017 Pointer increments SHALL wrap modulo 256 (0xFF+1=0x00); no error is flagged.
REQ-018 In DONE, SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-019 Timing, with start high in cycle 0: READ/WRITE SHALL alternate in cycles 1..2*len, and done SHALL be high in cycle 2*len+1. For len=0, done SHALL be high in cycle 1.
REQ-020 start while busy=1 SHALL be ignored, with no queuing. Changes to src_addr, dst_addr and len after the start cycle SHALL have no effect.
REQ-021 Overlapping ranges SHALL use strict forward byte-by-byte order: each byte is read after all earlier writes have committed.
REQ-022 mem_we SHALL be 1 only in WRITE. Outside WRITE, mem_wdata SHALL be 0. In IDLE and DONE, mem_addr SHALL be 0.

Reset
REQ-023 With RST=1 at a posedge, SHALL enter IDLE and clear src_ptr, dst_ptr, count and the holding register. From the next cycle, busy=0, done=0, mem_we=0, mem_addr=0 and mem_wdata=0.
REQ-024 RST SHALL have priority over start. Reset mid-transfer SHALL abort; bytes already written stay written, and no done pulse is issued.

Configuration
REQ-025 With macro MEMCPY_FILL_EN defined, SHALL add inputs fill_mode (1 bit) and fill_data (8 bits), latched with start.
REQ-026 With MEMCPY_FILL_EN defined and fill_mode=1:
- SHALL skip READ and go IDLE->WRITE.
- Each WRITE SHALL write the latched fill_data to dst_ptr.
- The FSM SHALL go WRITE->WRITE until count reaches 0.
- done SHALL be high in cycle len+1.
- src_ptr SHALL be unused.
REQ-027 Without MEMCPY_FILL_EN, the fill_mode and fill_data ports SHALL be absent and behaviour SHALL be copy-only as above.

Verification
REQ-028 mem[0x10..0x12]=0x0A,0x0B,0x0C; start with src=0x10, dst=0x40, len=3 -> mem[0x40..0x42]=0x0A,0x0B,0x0C; done high in cycle 7; busy high in cycles 1..7.
REQ-029 len=0, start -> done high in cycle 1; mem_we never asserted; memory unchanged.
REQ-030 src=0xFE, dst=0x20, len=3, mem[0xFE]=1, mem[0xFF]=2, mem[0x00]=3 -> mem[0x20..0x22]=1,2,3 (source wraps).
REQ-031 Overlap: mem[0x30]=0x55, src=0x30, dst=0x31, len=4 -> mem[0x31..0x34] all 0x55.
REQ-032 RST asserted in cycle 3 of a len=5 copy -> mem_we=0 and busy=0 from cycle 4; only the first byte was written; no done pulse; a new start afterwards completes normally.
REQ-033 (MEMCPY_FILL_EN) fill_mode=1, fill_data=0xA5, dst=0x80, len=4 -> mem[0x80..0x83]=0xA5; done high in cycle 5; start pulsed in cycle 2 is ignored.
